// File: rtl/gb_dma_pkg.sv
// gb_dma_pkg: shared types and constants for the Game Boy OAM DMA sequencer.
package gb_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } dma_state_t;

    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [7:0]  ECHO_LO      = 8'hE0;
    localparam logic [7:0]  ECHO_OFS     = 8'h20;
    localparam int          XFER_LEN_DEF = 160;

    // Pages E0..FF alias the work RAM 0x20 pages below them (echo RAM).
    function automatic logic [7:0] map_page(input logic [7:0] page);
        return (page >= ECHO_LO) ? (page - ECHO_OFS) : page;
    endfunction

endpackage

// File: rtl/gb_dma_ctrl.sv
// gb_dma_ctrl: OAM DMA sequencer. A rising edge of reg_write copies XFER_LEN
// bytes from {page,00} into OAM, one byte per XFER_CYCLES clocks.
// Optional feature macro: DMA_RESTART_EN (a write during a copy restarts it).
import gb_dma_pkg::*;

module gb_dma_ctrl #(
    parameter int XFER_CYCLES = 4,
    parameter int START_DELAY = 4,
    parameter int XFER_LEN    = XFER_LEN_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write,
    input  logic [7:0]  reg_din,
    output logic [7:0]  reg_dout,
    output logic [15:0] src_adr,
    output logic        src_read,
    input  logic [7:0]  src_din,
    output logic [7:0]  oam_adr,
    output logic [7:0]  oam_dout,
    output logic        oam_write,
    output logic        active
);

    localparam logic [7:0] START_LAST = 8'(START_DELAY - 1);
    localparam logic [7:0] READ_LAST  = 8'(XFER_CYCLES - 2);
    localparam logic [7:0] INDEX_LAST = 8'(XFER_LEN - 1);
    localparam logic [7:0] OAM_LO     = OAM_BASE[7:0];

    dma_state_t state, state_nx;
    logic       r_reg_write;
    logic       wr_edge;
    logic       start_copy;
    logic       load_byte;
    logic [7:0] page, page_nx;
    logic [7:0] index, index_nx;
    logic [7:0] cnt, cnt_nx;

    assign wr_edge = reg_write & ~r_reg_write;

`ifdef DMA_RESTART_EN
    assign start_copy = wr_edge;
`else
    assign start_copy = wr_edge & (state == IDLE);
`endif

    // Next-state logic: delay in START, read phase, single write, advance index.
    always_comb begin
        state_nx  = state;
        page_nx   = page;
        index_nx  = index;
        cnt_nx    = cnt;
        load_byte = 1'b0;
        case (state)
            IDLE: state_nx = IDLE;
            START: begin
                if (cnt == START_LAST) begin
                    state_nx = READ;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            READ: begin
                if (cnt == READ_LAST) begin
                    state_nx  = WRITE;
                    cnt_nx    = '0;
                    load_byte = 1'b1;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            WRITE: begin
                if (index == INDEX_LAST) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = READ;
                    index_nx = index + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (start_copy) begin
            state_nx = START;
            page_nx  = reg_din;
            index_nx = '0;
            cnt_nx   = '0;
        end
    end

    // Sequencer state, edge detector and copy position registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            r_reg_write <= 1'b0;
            page        <= '0;
            index       <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_nx;
            r_reg_write <= reg_write;
            page        <= page_nx;
            index       <= index_nx;
            cnt         <= cnt_nx;
        end
    end

    // Read-back register follows every CPU write; OAM data latched on the last read clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_dout <= '0;
            oam_dout <= '0;
        end else begin
            if (wr_edge) begin
                reg_dout <= reg_din;
            end
            if (load_byte) begin
                oam_dout <= src_din;
            end
        end
    end

    assign src_adr   = {map_page(page), index};
    assign oam_adr   = index + OAM_LO;
    assign src_read  = (state == READ);
    assign oam_write = (state == WRITE);
    assign active    = (state != IDLE);

endmodule
